issue_scheduler: RTL and testbench

- Reservation-station array plus wakeup/select logic between dispatch and the three functional units.
- Accepts up to two renamed instructions per cycle and tracks source-operand readiness against completion broadcasts.
- Each cycle it issues at most one instruction per FU: FU0 and FU1 are ALU-only; FU2 is memory-only (LW/SW).

---
 rtl/issue_scheduler.sv | 270 +++++++++++++++++++++++++++
 tb/tb_issue_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : issue_scheduler
// Description : Reservation-station array with wakeup/select feeding two ALU
//               pipes (FU0/FU1) and one memory pipe (FU2).
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler #(
    parameter int RS_DEPTH = 16,
    parameter int PREG_W   = 6,
    parameter int ROB_W    = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic [1:0]                  disp_valid,
    input  logic [1:0]                  disp_is_mem,
    input  logic [2*PREG_W-1:0]         disp_ps1,
    input  logic [2*PREG_W-1:0]         disp_ps2,
    input  logic [2*PREG_W-1:0]         disp_pd,
    input  logic [2*ROB_W-1:0]          disp_rob,
    input  logic [1:0]                  disp_s1_rdy,
    input  logic [1:0]                  disp_s2_rdy,
    input  logic [2*32-1:0]             disp_instr,
    output logic                        disp_ready,
    output logic [$clog2(RS_DEPTH):0]   free_cnt,
    input  logic [2:0]                  wb_valid,
    input  logic [3*PREG_W-1:0]         wb_pd,
    input  logic [2:0]                  fu_ready,
    output logic [2:0]                  iss_valid,
    output logic [3*PREG_W-1:0]         iss_ps1,
    output logic [3*PREG_W-1:0]         iss_ps2,
    output logic [3*PREG_W-1:0]         iss_pd,
    output logic [3*ROB_W-1:0]          iss_rob,
    output logic [3*32-1:0]             iss_instr
);

    localparam int c_IDX_W = $clog2(RS_DEPTH);
    localparam int c_CNT_W = c_IDX_W + 1;

    // Entry storage
    logic [RS_DEPTH-1:0] r_valid;
    logic [RS_DEPTH-1:0] r_is_mem;
    logic [RS_DEPTH-1:0] r_s1_rdy;
    logic [RS_DEPTH-1:0] r_s2_rdy;
    logic [PREG_W-1:0]   r_ps1   [RS_DEPTH];
    logic [PREG_W-1:0]   r_ps2   [RS_DEPTH];
    logic [PREG_W-1:0]   r_pd    [RS_DEPTH];
    logic [ROB_W-1:0]    r_rob   [RS_DEPTH];
    logic [31:0]         r_instr [RS_DEPTH];

    // Issue registers
    logic [2:0]          r_iss_valid;
    logic [3*PREG_W-1:0] r_iss_ps1;
    logic [3*PREG_W-1:0] r_iss_ps2;
    logic [3*PREG_W-1:0] r_iss_pd;
    logic [3*ROB_W-1:0]  r_iss_rob;
    logic [3*32-1:0]     r_iss_instr;

    // Combinational decisions
    logic [c_CNT_W-1:0]  w_nvalid;
    logic [c_CNT_W-1:0]  w_free_cnt;
    logic                w_disp_ready;
    logic [1:0]          w_ins_s1;
    logic [1:0]          w_ins_s2;
    logic [RS_DEPTH-1:0] w_wake1;
    logic [RS_DEPTH-1:0] w_wake2;
    logic [c_IDX_W-1:0]  w_a0;
    logic [c_IDX_W-1:0]  w_a1;
    logic                w_wr0;
    logic                w_wr1;
    logic [RS_DEPTH-1:0] w_alu_cand;
    logic [RS_DEPTH-1:0] w_mem_cand;
    logic [2:0]          w_sel_v;
    logic [c_IDX_W-1:0]  w_sel_idx [3];

    function automatic logic wb_hit(
        input logic [PREG_W-1:0]   tag,
        input logic [2:0]          v,
        input logic [3*PREG_W-1:0] pd
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (v[k] && (pd[k*PREG_W +: PREG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Occupancy is derived from the registered valid bits only
    always_comb begin
        w_nvalid = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_nvalid = w_nvalid + c_CNT_W'(r_valid[i]);
        end
    end

    assign w_free_cnt   = c_CNT_W'(RS_DEPTH) - w_nvalid;
    assign w_disp_ready = (w_free_cnt >= c_CNT_W'(2));
    assign free_cnt     = w_free_cnt;
    assign disp_ready   = w_disp_ready;

    // Insertion readiness includes a same-cycle broadcast so no wakeup is lost
    always_comb begin
        w_ins_s1 = '0;
        w_ins_s2 = '0;
        for (int l = 0; l < 2; l++) begin
            w_ins_s1[l] = disp_s1_rdy[l]
                        | (disp_ps1[l*PREG_W +: PREG_W] == '0)
                        | wb_hit(disp_ps1[l*PREG_W +: PREG_W], wb_valid, wb_pd);
            w_ins_s2[l] = disp_s2_rdy[l]
                        | (disp_ps2[l*PREG_W +: PREG_W] == '0)
                        | wb_hit(disp_ps2[l*PREG_W +: PREG_W], wb_valid, wb_pd);
        end
    end

    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_wake1[i] = r_valid[i] & wb_hit(r_ps1[i], wb_valid, wb_pd);
            w_wake2[i] = r_valid[i] & wb_hit(r_ps2[i], wb_valid, wb_pd);
        end
    end

    // Lowest and next-lowest free slots
    always_comb begin
        logic f0;
        logic f1;
        f0   = 1'b0;
        f1   = 1'b0;
        w_a0 = '0;
        w_a1 = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!r_valid[i]) begin
                if (!f0) begin
                    f0   = 1'b1;
                    w_a0 = c_IDX_W'(i);
                end else if (!f1) begin
                    f1   = 1'b1;
                    w_a1 = c_IDX_W'(i);
                end
            end
        end
    end

    assign w_wr0 = disp_valid[0] & w_disp_ready;
    assign w_wr1 = disp_valid[1] & w_disp_ready;

    assign w_alu_cand = r_valid & r_s1_rdy & r_s2_rdy & ~r_is_mem;
    assign w_mem_cand = r_valid & r_s1_rdy & r_s2_rdy &  r_is_mem;

    // Select: FU1 falls back to the oldest ALU candidate when FU0 is stalled
    always_comb begin
        logic               af0;
        logic               af1;
        logic               mf;
        logic [c_IDX_W-1:0] aidx0;
        logic [c_IDX_W-1:0] aidx1;
        logic [c_IDX_W-1:0] midx;
        af0   = 1'b0;
        af1   = 1'b0;
        mf    = 1'b0;
        aidx0 = '0;
        aidx1 = '0;
        midx  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_alu_cand[i]) begin
                if (!af0) begin
                    af0   = 1'b1;
                    aidx0 = c_IDX_W'(i);
                end else if (!af1) begin
                    af1   = 1'b1;
                    aidx1 = c_IDX_W'(i);
                end
            end
            if (w_mem_cand[i] && !mf) begin
                mf   = 1'b1;
                midx = c_IDX_W'(i);
            end
        end
        w_sel_v[0]   = fu_ready[0] & af0;
        w_sel_idx[0] = aidx0;
        if (fu_ready[0]) begin
            w_sel_v[1]   = fu_ready[1] & af1;
            w_sel_idx[1] = aidx1;
        end else begin
            w_sel_v[1]   = fu_ready[1] & af0;
            w_sel_idx[1] = aidx0;
        end
        w_sel_v[2]   = fu_ready[2] & mf;
        w_sel_idx[2] = midx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= '0;
            r_is_mem    <= '0;
            r_s1_rdy    <= '0;
            r_s2_rdy    <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_ps1[i]   <= '0;
                r_ps2[i]   <= '0;
                r_pd[i]    <= '0;
                r_rob[i]   <= '0;
                r_instr[i] <= '0;
            end
            r_iss_valid <= '0;
            r_iss_ps1   <= '0;
            r_iss_ps2   <= '0;
            r_iss_pd    <= '0;
            r_iss_rob   <= '0;
            r_iss_instr <= '0;
        end else if (flush) begin
            r_valid     <= '0;
            r_iss_valid <= '0;
        end else begin
            // Sticky wakeup; only valid entries can match
            r_s1_rdy <= r_s1_rdy | w_wake1;
            r_s2_rdy <= r_s2_rdy | w_wake2;

            for (int k = 0; k < 3; k++) begin
                if (w_sel_v[k]) begin
                    r_valid[w_sel_idx[k]]             <= 1'b0;
                    r_iss_ps1[k*PREG_W +: PREG_W]     <= r_ps1[w_sel_idx[k]];
                    r_iss_ps2[k*PREG_W +: PREG_W]     <= r_ps2[w_sel_idx[k]];
                    r_iss_pd[k*PREG_W +: PREG_W]      <= r_pd[w_sel_idx[k]];
                    r_iss_rob[k*ROB_W +: ROB_W]       <= r_rob[w_sel_idx[k]];
                    r_iss_instr[k*32 +: 32]           <= r_instr[w_sel_idx[k]];
                end
            end
            r_iss_valid <= w_sel_v;

            // Allocation targets free slots, so it never collides with issue or wakeup
            if (w_wr0) begin
                r_valid[w_a0]  <= 1'b1;
                r_is_mem[w_a0] <= disp_is_mem[0];
                r_s1_rdy[w_a0] <= w_ins_s1[0];
                r_s2_rdy[w_a0] <= w_ins_s2[0];
                r_ps1[w_a0]    <= disp_ps1[0 +: PREG_W];
                r_ps2[w_a0]    <= disp_ps2[0 +: PREG_W];
                r_pd[w_a0]     <= disp_pd[0 +: PREG_W];
                r_rob[w_a0]    <= disp_rob[0 +: ROB_W];
                r_instr[w_a0]  <= disp_instr[0 +: 32];
            end
            if (w_wr1) begin
                r_valid[w_a1]  <= 1'b1;
                r_is_mem[w_a1] <= disp_is_mem[1];
                r_s1_rdy[w_a1] <= w_ins_s1[1];
                r_s2_rdy[w_a1] <= w_ins_s2[1];
                r_ps1[w_a1]    <= disp_ps1[PREG_W +: PREG_W];
                r_ps2[w_a1]    <= disp_ps2[PREG_W +: PREG_W];
                r_pd[w_a1]     <= disp_pd[PREG_W +: PREG_W];
                r_rob[w_a1]    <= disp_rob[ROB_W +: ROB_W];
                r_instr[w_a1]  <= disp_instr[32 +: 32];
            end
        end
    end

    assign iss_valid = r_iss_valid;
    assign iss_ps1   = r_iss_ps1;
    assign iss_ps2   = r_iss_ps2;
    assign iss_pd    = r_iss_pd;
    assign iss_rob   = r_iss_rob;
    assign iss_instr = r_iss_instr;

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scheduler
// Description : Directed self-checking bench for issue_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scheduler;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic [1:0]  disp_valid;
    logic [1:0]  disp_is_mem;
    logic [11:0] disp_ps1;
    logic [11:0] disp_ps2;
    logic [11:0] disp_pd;
    logic [7:0]  disp_rob;
    logic [1:0]  disp_s1_rdy;
    logic [1:0]  disp_s2_rdy;
    logic [63:0] disp_instr;
    logic        disp_ready;
    logic [4:0]  free_cnt;
    logic [2:0]  wb_valid;
    logic [17:0] wb_pd;
    logic [2:0]  fu_ready;
    logic [2:0]  iss_valid;
    logic [17:0] iss_ps1;
    logic [17:0] iss_ps2;
    logic [17:0] iss_pd;
    logic [11:0] iss_rob;
    logic [95:0] iss_instr;

    int checks = 0;
    int errors = 0;

    issue_scheduler #(.RS_DEPTH(16), .PREG_W(6), .ROB_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .disp_valid(disp_valid), .disp_is_mem(disp_is_mem),
        .disp_ps1(disp_ps1), .disp_ps2(disp_ps2), .disp_pd(disp_pd),
        .disp_rob(disp_rob), .disp_s1_rdy(disp_s1_rdy), .disp_s2_rdy(disp_s2_rdy),
        .disp_instr(disp_instr), .disp_ready(disp_ready), .free_cnt(free_cnt),
        .wb_valid(wb_valid), .wb_pd(wb_pd), .fu_ready(fu_ready),
        .iss_valid(iss_valid), .iss_ps1(iss_ps1), .iss_ps2(iss_ps2),
        .iss_pd(iss_pd), .iss_rob(iss_rob), .iss_instr(iss_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        disp_valid  = '0;
        disp_is_mem = '0;
        disp_ps1    = '0;
        disp_ps2    = '0;
        disp_pd     = '0;
        disp_rob    = '0;
        disp_s1_rdy = '0;
        disp_s2_rdy = '0;
        disp_instr  = '0;
        wb_valid    = '0;
        wb_pd       = '0;
        flush       = 1'b0;
    endtask

    task automatic set_lane(input int lane, input logic is_mem, input logic [5:0] ps1,
                            input logic s1r, input logic [5:0] ps2, input logic s2r,
                            input logic [5:0] pd, input logic [3:0] rob);
        disp_valid[lane]        = 1'b1;
        disp_is_mem[lane]       = is_mem;
        disp_ps1[lane*6 +: 6]   = ps1;
        disp_ps2[lane*6 +: 6]   = ps2;
        disp_pd[lane*6 +: 6]    = pd;
        disp_rob[lane*4 +: 4]   = rob;
        disp_s1_rdy[lane]       = s1r;
        disp_s2_rdy[lane]       = s2r;
        disp_instr[lane*32 +: 32] = 32'hC0DE_0000 | {26'd0, pd};
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        fu_ready = 3'b111;
        clear_inputs();
        #12;
        checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL reset_iss_valid actual=%b expected=000", iss_valid); end
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL reset_free_cnt actual=%0d expected=16", free_cnt); end
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready actual=%b expected=1", disp_ready); end
        checks++; if (iss_pd !== 18'd0) begin errors++; $display("FAIL reset_iss_pd actual=%h expected=0", iss_pd); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_issue;
        set_lane(0, 1'b0, 6'd3, 1'b1, 6'd4, 1'b1, 6'd10, 4'd2);
        tick();
        clear_inputs();
        checks++; if (free_cnt !== 5'd15) begin errors++; $display("FAIL basic_free_after_disp actual=%0d expected=15", free_cnt); end
        checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL basic_no_same_cycle actual=%b expected=000", iss_valid); end
        tick();
        checks++; if (iss_valid !== 3'b001) begin errors++; $display("FAIL basic_iss_valid actual=%b expected=001", iss_valid); end
        checks++; if (iss_pd[5:0] !== 6'd10) begin errors++; $display("FAIL basic_iss_pd actual=%0d expected=10", iss_pd[5:0]); end
        checks++; if (iss_rob[3:0] !== 4'd2) begin errors++; $display("FAIL basic_iss_rob actual=%0d expected=2", iss_rob[3:0]); end
        checks++; if (iss_ps1[5:0] !== 6'd3 || iss_ps2[5:0] !== 6'd4) begin errors++; $display("FAIL basic_iss_srcs actual=%0d/%0d expected=3/4", iss_ps1[5:0], iss_ps2[5:0]); end
        checks++; if (iss_instr[31:0] !== 32'hC0DE_000A) begin errors++; $display("FAIL basic_iss_instr actual=%h expected=c0de000a", iss_instr[31:0]); end
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL basic_free_after_issue actual=%0d expected=16", free_cnt); end
        tick();
        checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL basic_strobe_drop actual=%b expected=000", iss_valid); end
        checks++; if (iss_pd[5:0] !== 6'd10) begin errors++; $display("FAIL basic_hold_pd actual=%0d expected=10", iss_pd[5:0]); end
    endtask

    task automatic test_wakeup;
        set_lane(0, 1'b0, 6'd5, 1'b0, 6'd6, 1'b1, 6'd11, 4'd3);
        tick();
        clear_inputs();
        tick();
        checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL wake_early1 actual=%b expected=000", iss_valid); end
        wb_valid = 3'b100;
        wb_pd[17:12] = 6'd5;
        tick();
        clear_inputs();
        checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL wake_early2 actual=%b expected=000", iss_valid); end
        tick();
        checks++; if (iss_valid !== 3'b001) begin errors++; $display("FAIL wake_issue actual=%b expected=001", iss_valid); end
        checks++; if (iss_pd[5:0] !== 6'd11) begin errors++; $display("FAIL wake_pd actual=%0d expected=11", iss_pd[5:0]); end
        tick();
    endtask

    task automatic test_bypass;
        set_lane(0, 1'b0, 6'd7, 1'b0, 6'd8, 1'b1, 6'd12, 4'd4);
        wb_valid = 3'b010;
        wb_pd[11:6] = 6'd7;
        tick();
        clear_inputs();
        checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL bypass_early actual=%b expected=000", iss_valid); end
        tick();
        checks++; if (iss_valid !== 3'b001) begin errors++; $display("FAIL bypass_issue actual=%b expected=001", iss_valid); end
        checks++; if (iss_pd[5:0] !== 6'd12) begin errors++; $display("FAIL bypass_pd actual=%0d expected=12", iss_pd[5:0]); end
        tick();
    endtask

    task automatic test_multi_issue;
        fu_ready = 3'b000;
        set_lane(0, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd20, 4'd5);
        set_lane(1, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd21, 4'd6);
        tick();
        clear_inputs();
        set_lane(0, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd22, 4'd7);
        set_lane(1, 1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd23, 4'd8);
        tick();
        clear_inputs();
        checks++; if (free_cnt !== 5'd12) begin errors++; $display("FAIL multi_free_setup actual=%0d expected=12", free_cnt); end
        fu_ready = 3'b111;
        tick();
        fu_ready = 3'b010;
        checks++; if (iss_valid !== 3'b111) begin errors++; $display("FAIL multi_iss_valid actual=%b expected=111", iss_valid); end
        checks++; if (iss_pd !== {6'd23, 6'd21, 6'd20}) begin errors++; $display("FAIL multi_iss_pd actual=%h expected=%h", iss_pd, {6'd23, 6'd21, 6'd20}); end
        checks++; if (iss_rob !== {4'd8, 4'd6, 4'd5}) begin errors++; $display("FAIL multi_iss_rob actual=%h expected=865", iss_rob); end
        checks++; if (free_cnt !== 5'd15) begin errors++; $display("FAIL multi_free_after actual=%0d expected=15", free_cnt); end
        tick();
        checks++; if (iss_valid !== 3'b010) begin errors++; $display("FAIL fallback_iss_valid actual=%b expected=010", iss_valid); end
        checks++; if (iss_pd[11:6] !== 6'd22) begin errors++; $display("FAIL fallback_pd actual=%0d expected=22", iss_pd[11:6]); end
        checks++; if (iss_pd[5:0] !== 6'd20) begin errors++; $display("FAIL fallback_hold_fu0 actual=%0d expected=20", iss_pd[5:0]); end
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL fallback_free actual=%0d expected=16", free_cnt); end
        fu_ready = 3'b111;
        tick();
    endtask

    task automatic test_full;
        fu_ready = 3'b000;
        for (int n = 0; n < 7; n++) begin
            set_lane(0, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'(30 + 2*n), 4'(n));
            set_lane(1, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'(31 + 2*n), 4'(n));
            tick();
            clear_inputs();
        end
        set_lane(0, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd44, 4'd14);
        tick();
        clear_inputs();
        checks++; if (free_cnt !== 5'd1) begin errors++; $display("FAIL full_free actual=%0d expected=1", free_cnt); end
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_disp_ready actual=%b expected=0", disp_ready); end
        set_lane(0, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd45, 4'd15);
        set_lane(1, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd46, 4'd15);
        tick();
        clear_inputs();
        checks++; if (free_cnt !== 5'd1) begin errors++; $display("FAIL full_ignored actual=%0d expected=1", free_cnt); end
        fu_ready = 3'b001;
        tick();
        fu_ready = 3'b000;
        checks++; if (iss_valid !== 3'b001 || iss_pd[5:0] !== 6'd30) begin errors++; $display("FAIL full_issue actual=%b/%0d expected=001/30", iss_valid, iss_pd[5:0]); end
        checks++; if (free_cnt !== 5'd2 || disp_ready !== 1'b1) begin errors++; $display("FAIL full_reopen actual=%0d/%b expected=2/1", free_cnt, disp_ready); end
        flush = 1'b1;
        tick();
        clear_inputs();
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL full_cleanup actual=%0d expected=16", free_cnt); end
    endtask

    task automatic test_flush;
        fu_ready = 3'b000;
        for (int n = 0; n < 4; n++) begin
            set_lane(0, 1'b0, 6'd40, (n == 0), 6'd2, 1'b1, 6'(50 + 2*n), 4'(n));
            set_lane(1, 1'b0, 6'd40, (n == 0), 6'd2, 1'b1, 6'(51 + 2*n), 4'(n));
            tick();
            clear_inputs();
        end
        checks++; if (free_cnt !== 5'd8) begin errors++; $display("FAIL flush_setup actual=%0d expected=8", free_cnt); end
        fu_ready = 3'b111;
        flush = 1'b1;
        set_lane(0, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd60, 4'd9);
        tick();
        clear_inputs();
        checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL flush_iss_valid actual=%b expected=000", iss_valid); end
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL flush_free actual=%0d expected=16", free_cnt); end
        tick();
        checks++; if (iss_valid !== 3'b000 || free_cnt !== 5'd16) begin errors++; $display("FAIL flush_dropped_disp actual=%b/%0d expected=000/16", iss_valid, free_cnt); end
    endtask

    task automatic test_async_reset;
        fu_ready = 3'b111;
        set_lane(0, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd50, 4'd9);
        set_lane(1, 1'b0, 6'd41, 1'b0, 6'd2, 1'b1, 6'd51, 4'd10);
        tick();
        clear_inputs();
        tick();
        checks++; if (iss_valid !== 3'b001 || iss_pd[5:0] !== 6'd50) begin errors++; $display("FAIL areset_pre_issue actual=%b/%0d expected=001/50", iss_valid, iss_pd[5:0]); end
        checks++; if (free_cnt !== 5'd15) begin errors++; $display("FAIL areset_pre_free actual=%0d expected=15", free_cnt); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL areset_iss_valid actual=%b expected=000", iss_valid); end
        checks++; if (iss_pd !== 18'd0 || iss_rob !== 12'd0 || iss_instr !== 96'd0) begin errors++; $display("FAIL areset_fields actual=%h/%h/%h expected=0", iss_pd, iss_rob, iss_instr); end
        checks++; if (free_cnt !== 5'd16 || disp_ready !== 1'b1) begin errors++; $display("FAIL areset_free actual=%0d/%b expected=16/1", free_cnt, disp_ready); end
        #1;
        reset_n = 1'b1;
        tick();
        checks++; if (free_cnt !== 5'd16 || iss_valid !== 3'b000) begin errors++; $display("FAIL areset_after actual=%0d/%b expected=16/000", free_cnt, iss_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_bypass();
        test_multi_issue();
        test_full();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
